// File: rtl/axum_wb_arbiter.sv
// Writeback arbiter for the Axum integer register file: pipeline port A wins, port B is buffered.
// Define AXUM_WB_STARVE_GUARD_EN to enable the port-B starvation counter and stall_o.
module axum_wb_arbiter #(
   parameter int DataWidth   = 32,
   parameter int Depth       = 2,
   parameter int StarveLimit = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 a_we_i,
   input  logic [4:0]           a_waddr_i,
   input  logic [DataWidth-1:0] a_wdata_i,
   input  logic                 b_valid_i,
   output logic                 b_ready_o,
   input  logic [4:0]           b_waddr_i,
   input  logic [DataWidth-1:0] b_wdata_i,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   input  logic [4:0]           raddr_c_i,
   output logic                 hazard_a_o,
   output logic                 hazard_b_o,
   output logic                 hazard_c_o,
   output logic                 stall_o,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 fifo_empty_o
);

   localparam int PtrW = (Depth > 2) ? 2 : 1;
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(Depth);

   logic [Depth-1:0]     valid_q, valid_d;
   logic [4:0]           waddr_q [Depth];
   logic [4:0]           waddr_d [Depth];
   logic [DataWidth-1:0] wdata_q [Depth];
   logic [DataWidth-1:0] wdata_d [Depth];
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]      count_q, count_d;

   logic a_win;
   logic head_alloc;
   logic pop;
   logic push;

   always_comb begin
      a_win      = a_we_i && (a_waddr_i != 5'd0);
      head_alloc = (count_q != '0);
      pop        = !rst_i && !a_win && head_alloc;
      b_ready_o  = !rst_i && (count_q != DepthC);
      push       = b_valid_i && b_ready_o && (b_waddr_i != 5'd0);
   end

   // Register-file write port: A first, then the FIFO head (killed heads drain with we low).
   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = 5'd0;
      rf_wdata_o = '0;
      if (!rst_i) begin
         if (a_win) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = a_waddr_i;
            rf_wdata_o = a_wdata_i;
         end else if (head_alloc) begin
            rf_we_o    = valid_q[rd_ptr_q];
            rf_waddr_o = waddr_q[rd_ptr_q];
            rf_wdata_o = wdata_q[rd_ptr_q];
         end
      end
   end

   always_comb begin
      valid_d  = valid_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      // Kill precedes push so a same-cycle B result to the A register survives.
      if (a_win) begin
         for (int i = 0; i < Depth; i++) begin
            if (waddr_q[i] == a_waddr_i) valid_d[i] = 1'b0;
         end
      end
      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PtrW'(1);
      end
      if (push) begin
         valid_d[wr_ptr_q] = 1'b1;
         waddr_d[wr_ptr_q] = b_waddr_i;
         wdata_d[wr_ptr_q] = b_wdata_i;
         wr_ptr_d          = wr_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
   end

   always_comb begin
      hazard_a_o = 1'b0;
      hazard_b_o = 1'b0;
      hazard_c_o = 1'b0;
      for (int i = 0; i < Depth; i++) begin
         if (valid_q[i]) begin
            if (waddr_q[i] == raddr_a_i) hazard_a_o = 1'b1;
            if (waddr_q[i] == raddr_b_i) hazard_b_o = 1'b1;
            if (waddr_q[i] == raddr_c_i) hazard_c_o = 1'b1;
         end
      end
      if (raddr_a_i == 5'd0) hazard_a_o = 1'b0;
      if (raddr_b_i == 5'd0) hazard_b_o = 1'b0;
      if (raddr_c_i == 5'd0) hazard_c_o = 1'b0;
      fifo_empty_o = ~|valid_q;
   end

`ifdef AXUM_WB_STARVE_GUARD_EN
   logic [3:0] starve_q, starve_d;
   logic       stall_q, stall_d;
   logic       starve_clr;

   // Counts cycles a valid buffered write loses to port A; any pop or an empty FIFO restarts it.
   always_comb begin
      starve_clr = pop || fifo_empty_o;
      starve_d   = starve_q;
      if (starve_clr) begin
         starve_d = 4'd0;
      end else if (a_win && (starve_q != 4'hF)) begin
         starve_d = starve_q + 4'd1;
      end
      stall_d = !starve_clr && (starve_q >= 4'(StarveLimit));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_q <= 4'd0;
         stall_q  <= 1'b0;
      end else begin
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   assign stall_o = stall_q;

   a_we_during_stall: assert property (@(posedge clk_i) disable iff (rst_i) !(a_we_i && stall_q));
`else
   assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_axum_wb_arbiter.sv
// Directed bench for axum_wb_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_axum_wb_arbiter;

   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          a_we_i;
   logic [4:0]    a_waddr_i;
   logic [DW-1:0] a_wdata_i;
   logic          b_valid_i;
   logic          b_ready_o;
   logic [4:0]    b_waddr_i;
   logic [DW-1:0] b_wdata_i;
   logic [4:0]    raddr_a_i, raddr_b_i, raddr_c_i;
   logic          hazard_a_o, hazard_b_o, hazard_c_o;
   logic          stall_o;
   logic          rf_we_o;
   logic [4:0]    rf_waddr_o;
   logic [DW-1:0] rf_wdata_o;
   logic          fifo_empty_o;

   axum_wb_arbiter #(.DataWidth(DW), .Depth(DEPTH), .StarveLimit(LIMIT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .a_we_i(a_we_i), .a_waddr_i(a_waddr_i), .a_wdata_i(a_wdata_i),
      .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_waddr_i(b_waddr_i), .b_wdata_i(b_wdata_i),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
      .hazard_a_o(hazard_a_o), .hazard_b_o(hazard_b_o), .hazard_c_o(hazard_c_o),
      .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .fifo_empty_o(fifo_empty_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: ordered list of buffered writes, oldest first.
   typedef struct packed {
      logic        v;
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   ent_t        ent;
   logic        model_on = 1'b0;
   int          m_lost   = 0;
   logic        m_stall  = 1'b0;
   logic        awin, anyv, mpop, mpush, exp_we;
   logic [4:0]  exp_wa;
   logic [31:0] exp_wd;
   logic [31:0] shadow [32];

   function automatic logic m_haz(input logic [4:0] ra);
      if (ra == 5'd0) return 1'b0;
      foreach (mq[i]) if (mq[i].v && mq[i].a == ra) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk_i) begin
      if (!rst_i && rf_we_o) shadow[rf_waddr_o] <= rf_wdata_o;
   end

   // Compare on the falling edge, then advance the model by the coming rising edge.
   always @(negedge clk_i) begin
      awin = a_we_i && (a_waddr_i != 5'd0);
      anyv = 1'b0;
      foreach (mq[i]) if (mq[i].v) anyv = 1'b1;
      exp_we = 1'b0;
      exp_wa = 5'd0;
      exp_wd = 32'd0;
      if (!rst_i) begin
         if (awin) begin
            exp_we = 1'b1;
            exp_wa = a_waddr_i;
            exp_wd = a_wdata_i;
         end else if (mq.size() > 0) begin
            exp_we = mq[0].v;
            exp_wa = mq[0].a;
            exp_wd = mq[0].d;
         end
      end
      if (model_on) begin
         chk("m_b_ready", b_ready_o, !rst_i && (mq.size() != DEPTH));
         chk("m_fifo_empty", fifo_empty_o, !anyv);
         chk("m_rf_we", rf_we_o, exp_we);
         if (exp_we || rst_i || awin || mq.size() == 0) begin
            chk("m_rf_waddr", rf_waddr_o, exp_wa);
            chk("m_rf_wdata", rf_wdata_o, exp_wd);
         end
         chk("m_hazard_a", hazard_a_o, m_haz(raddr_a_i));
         chk("m_hazard_b", hazard_b_o, m_haz(raddr_b_i));
         chk("m_hazard_c", hazard_c_o, m_haz(raddr_c_i));
         chk("m_stall", stall_o, m_stall);
      end
      if (rst_i) begin
         mq.delete();
         m_lost   = 0;
         m_stall  = 1'b0;
         model_on = 1'b1;
      end else if (model_on) begin
         mpop  = !awin && (mq.size() > 0);
         mpush = b_valid_i && (mq.size() != DEPTH) && (b_waddr_i != 5'd0);
`ifdef AXUM_WB_STARVE_GUARD_EN
         m_stall = (m_lost >= LIMIT) && !mpop && anyv;
         if (mpop || !anyv) m_lost = 0;
         else if (awin && m_lost < 15) m_lost = m_lost + 1;
`endif
         if (awin) begin
            foreach (mq[i]) begin
               if (mq[i].a == a_waddr_i) begin
                  ent      = mq[i];
                  ent.v    = 1'b0;
                  mq[i]    = ent;
               end
            end
         end
         if (mpop) void'(mq.pop_front());
         if (mpush) begin
            ent.v = 1'b1;
            ent.a = b_waddr_i;
            ent.d = b_wdata_i;
            mq.push_back(ent);
         end
      end
   end

   task automatic nxt();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      a_we_i    = 1'b0;
      a_waddr_i = 5'd0;
      a_wdata_i = '0;
      b_valid_i = 1'b0;
      b_waddr_i = 5'd0;
      b_wdata_i = '0;
   endtask

   task automatic a_wr(input logic [4:0] a, input logic [31:0] d);
      a_we_i    = 1'b1;
      a_waddr_i = a;
      a_wdata_i = d;
   endtask

   task automatic b_wr(input logic [4:0] a, input logic [31:0] d);
      b_valid_i = 1'b1;
      b_waddr_i = a;
      b_wdata_i = d;
   endtask

   initial begin
      rst_i = 1'b1;
      idle();
      raddr_a_i = 5'd0;
      raddr_b_i = 5'd0;
      raddr_c_i = 5'd0;
      nxt();
      @(negedge clk_i);
      chk("rst_b_ready", b_ready_o, 1'b0);
      chk("rst_fifo_empty", fifo_empty_o, 1'b1);
      chk("rst_rf_we", rf_we_o, 1'b0);
      chk("rst_rf_waddr", rf_waddr_o, 5'd0);
      chk("rst_stall", stall_o, 1'b0);
      nxt();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_b_ready", b_ready_o, 1'b1);
      nxt();

      // Port-B write only
      b_wr(5'd5, 32'hDEAD_BEEF);
      raddr_a_i = 5'd5;
      @(negedge clk_i);
      chk("b_only_haz_push", hazard_a_o, 1'b0);
      nxt();
      idle();
      @(negedge clk_i);
      chk("b_only_we", rf_we_o, 1'b1);
      chk("b_only_waddr", rf_waddr_o, 5'd5);
      chk("b_only_wdata", rf_wdata_o, 32'hDEAD_BEEF);
      chk("b_only_haz", hazard_a_o, 1'b1);
      nxt();
      @(negedge clk_i);
      chk("b_only_haz_drop", hazard_a_o, 1'b0);
      chk("b_only_we_after", rf_we_o, 1'b0);
      nxt();
      raddr_a_i = 5'd0;

      // Fill and drain while port A is busy
      a_wr(5'd1, 32'h11);
      b_wr(5'd6, 32'h66);
      @(negedge clk_i);
      chk("fill_ready0", b_ready_o, 1'b1);
      nxt();
      a_wr(5'd2, 32'h22);
      b_wr(5'd7, 32'h77);
      @(negedge clk_i);
      chk("fill_ready1", b_ready_o, 1'b1);
      nxt();
      idle();
      a_wr(5'd3, 32'h33);
      @(negedge clk_i);
      chk("fill_full", b_ready_o, 1'b0);
      chk("fill_a_wins", rf_waddr_o, 5'd3);
      nxt();
      idle();
      @(negedge clk_i);
      chk("drain_x6_addr", rf_waddr_o, 5'd6);
      chk("drain_x6_data", rf_wdata_o, 32'h66);
      chk("drain_still_full", b_ready_o, 1'b0);
      nxt();
      @(negedge clk_i);
      chk("drain_x7_addr", rf_waddr_o, 5'd7);
      chk("drain_ready_back", b_ready_o, 1'b1);
      nxt();
      @(negedge clk_i);
      chk("drain_empty", fifo_empty_o, 1'b1);
      nxt();

      // Kill by younger port-A write
      b_wr(5'd8, 32'd1);
      raddr_b_i = 5'd8;
      nxt();
      idle();
      a_wr(5'd8, 32'd2);
      @(negedge clk_i);
      chk("kill_haz_before", hazard_b_o, 1'b1);
      chk("kill_a_data", rf_wdata_o, 32'd2);
      nxt();
      idle();
      @(negedge clk_i);
      chk("kill_silent_pop", rf_we_o, 1'b0);
      chk("kill_haz_after", hazard_b_o, 1'b0);
      chk("kill_empty", fifo_empty_o, 1'b1);
      nxt();
      @(negedge clk_i);
      chk("kill_rf_x8", shadow[8], 32'd2);
      chk("kill_ready", b_ready_o, 1'b1);
      nxt();
      raddr_b_i = 5'd0;

      // x0 writes on both ports
      a_wr(5'd0, 32'h99);
      b_wr(5'd0, 32'h55);
      @(negedge clk_i);
      chk("x0_ready", b_ready_o, 1'b1);
      chk("x0_we", rf_we_o, 1'b0);
      nxt();
      idle();
      @(negedge clk_i);
      chk("x0_we_after", rf_we_o, 1'b0);
      chk("x0_empty", fifo_empty_o, 1'b1);
      chk("x0_haz", hazard_a_o, 1'b0);
      nxt();

      // Concurrent push to the A register, then push and pop together
      b_wr(5'd9, 32'h90);
      nxt();
      idle();
      a_wr(5'd10, 32'hA0);
      b_wr(5'd10, 32'hB0);
      @(negedge clk_i);
      chk("same_a_data", rf_wdata_o, 32'hA0);
      nxt();
      idle();
      b_wr(5'd11, 32'hB1);
      raddr_b_i = 5'd9;
      raddr_c_i = 5'd10;
      @(negedge clk_i);
      chk("pp_full", b_ready_o, 1'b0);
      chk("pp_pop_x9", rf_wdata_o, 32'h90);
      chk("pp_haz_b", hazard_b_o, 1'b1);
      chk("pp_haz_c", hazard_c_o, 1'b1);
      nxt();
      @(negedge clk_i);
      chk("pp_pop_x10_kept", rf_wdata_o, 32'hB0);
      chk("pp_ready", b_ready_o, 1'b1);
      nxt();
      idle();
      @(negedge clk_i);
      chk("pp_pop_x11", rf_waddr_o, 5'd11);
      chk("pp_haz_c_gone", hazard_c_o, 1'b0);
      nxt();
      raddr_b_i = 5'd0;
      raddr_c_i = 5'd0;
      nxt();

      // Starvation: one buffered entry while port A keeps winning
      b_wr(5'd12, 32'hC);
      nxt();
      idle();
      for (int k = 0; k < 5; k++) begin
         a_wr(5'd13, 32'd100 + k);
         @(negedge clk_i);
         chk("starve_no_stall", stall_o, 1'b0);
         nxt();
      end
      idle();
      @(negedge clk_i);
`ifdef AXUM_WB_STARVE_GUARD_EN
      chk("starve_stall", stall_o, 1'b1);
`else
      chk("starve_no_guard", stall_o, 1'b0);
`endif
      chk("starve_pop", rf_waddr_o, 5'd12);
      nxt();
      @(negedge clk_i);
      chk("starve_release", stall_o, 1'b0);
      nxt();

      // Reset with two buffered writes
      a_wr(5'd1, 32'h1);
      b_wr(5'd14, 32'hE);
      nxt();
      a_wr(5'd2, 32'h2);
      b_wr(5'd15, 32'hF);
      nxt();
      idle();
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("mid_rst_ready", b_ready_o, 1'b0);
      chk("mid_rst_we", rf_we_o, 1'b0);
      nxt();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("mid_rst_empty", fifo_empty_o, 1'b1);
      chk("mid_rst_ready_back", b_ready_o, 1'b1);
      chk("mid_rst_no_write", rf_we_o, 1'b0);
      nxt();
      @(negedge clk_i);
      chk("mid_rst_no_write2", rf_we_o, 1'b0);
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axum_wb_arbiter.md
# axum_wb_arbiter

Writeback arbiter in front of the single write port of the Axum integer register file. It merges two result sources: the in-order pipeline writeback (port A, no backpressure, always wins) and long-latency results from load/multdiv (port B, valid/ready, buffered in a small FIFO). It raises per-read-port hazard flags for registers with a buffered write still pending. It also cancels buffered writes made stale by a younger port-A write to the same register.

## Interface
Parameters:
- DataWidth, 32, register width.
- Depth, 2, port-B FIFO entries; legal values 2 or 4.
- StarveLimit, 4, consecutive cycles a non-empty FIFO may lose to port A before stall_o asserts; range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- a_we_i  in  1  port-A write request (pipeline writeback).
- a_waddr_i  in  5  port-A destination register.
- a_wdata_i  in  DataWidth  port-A data.
- b_valid_i  in  1  port-B result valid.
- b_ready_o  out  1  port-B accept; reset value 0.
- b_waddr_i  in  5  port-B destination register.
- b_wdata_i  in  DataWidth  port-B data.
- raddr_a_i / raddr_b_i / raddr_c_i  in  5 each  decode read addresses to check.
- hazard_a_o / hazard_b_o / hazard_c_o  out  1 each  pending-write hit; reset value 0.
- stall_o  out  1  request the pipeline to hold off port A; reset value 0.
- rf_we_o  out  1  register-file write enable; reset value 0.
- rf_waddr_o  out  5  register-file write address; reset value 0.
- rf_wdata_o  out  DataWidth  register-file write data; reset value 0.
- fifo_empty_o  out  1  no valid FIFO entries; reset value 1.

## Operation
- FIFO: Depth entries, each {valid, waddr, wdata}, circular rd/wr pointers plus an occupancy count. Count covers allocated slots, including killed ones.
- b_ready_o = !rst_i && (count != Depth).
- Push: on b_valid_i && b_ready_o. Writes to x0 are accepted but not enqueued.
- Arbitration, combinational:
  - If a_we_i && a_waddr_i != 0, drive the A write to the rf port.
  - Else if the head entry is allocated, pop it. Drive the rf port with its waddr/wdata and rf_we_o = head.valid. A killed head pops silently with rf_we_o = 0.
  - Else rf_we_o = 0 and the addr/data outputs are 0.
- During rst_i, all rf outputs are 0.
- Kill rule: when an A write is driven to the rf port, every allocated entry with waddr == a_waddr_i has its valid bit cleared at that edge. The younger pipeline value must persist.
- Simultaneous push and pop in one cycle is legal; count is unchanged.
- A push whose waddr equals a concurrent A write is not killed, because the B result is younger.
- hazard_x_o = raddr_x_i != 0 && any valid entry has waddr == raddr_x_i. This is combinational on current FIFO state and excludes the incoming push.
- fifo_empty_o = no valid entries (killed slots count as empty).
- Reset: pointers, count, valid bits, starve counter and stall_o all cleared at the first edge with rst_i high. Buffered writes in flight are discarded, never written.

## Timing
- Port A: 0-cycle combinational path to the rf port; the register is written at the next edge.
- Port B: accepted at edge N, earliest rf write in cycle N+1. There is no empty-FIFO bypass.
- The hazard flag drops in the cycle after the matching entry is popped or killed.
- stall_o is registered and asserts one cycle after the starve counter reaches StarveLimit.
- b_ready_o deasserts in the cycle after the FIFO becomes full; there is no same-cycle recovery from a pop.

## Configuration
- AXUM_WB_STARVE_GUARD_EN defined:
  - A 4-bit starve counter increments each cycle in which the FIFO holds a valid entry and port A wins.
  - The counter clears on any pop, on reset, or when the FIFO is empty.
  - stall_o <= (counter >= StarveLimit).
  - The pipeline must keep a_we_i low while stall_o = 1. A simulation assertion flags a_we_i && stall_o.
- Undefined: no counter, stall_o tied 0, port A always wins.

## Test plan
- Port-B write only: push x5 = 0xDEAD_BEEF at cycle 0 -> rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xDEAD_BEEF in cycle 1. hazard_a_o = 1 for raddr_a_i = 5 in cycle 1 only.
- Fill and drain (Depth = 2), with a_we_i held high to x1..x3 for 3 cycles: B pushes x6 and x7 -> b_ready_o = 0 after the 2nd push. B writes reach rf in order x6, x7 once A idles, and b_ready_o returns to 1 after the first pop.
- Kill: push x8 = 1; next cycle A writes x8 = 2 -> the x8 entry is invalidated, the head pops silently, and the final rf content of x8 is 2. hazard_*_o for x8 = 0 from the following cycle.
- x0 writes: B push and A write to x0 -> no rf_we_o pulse, the FIFO stays empty, and hazards stay 0 for raddr = 0.
- Starvation (macro defined, StarveLimit = 4): FIFO holds one entry while a_we_i stays high -> stall_o rises after 4 lost cycles. With a_we_i then low, the entry pops and stall_o falls in the next cycle.
- Reset mid-operation: two entries buffered, rst_i pulsed for 1 cycle -> fifo_empty_o = 1, b_ready_o = 0 during reset and 1 after, and no rf write of the discarded entries.
